// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - binary32 constants, unpacked operand type and classification helpers
package fp32_pkg;

    localparam int          EXP_BIAS  = 127;
    localparam int          EXP_MAX   = 255;
    localparam int          FRAC_W    = 23;
    localparam logic [31:0] CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF   = 32'h7F800000;
    localparam logic [31:0] NEG_INF   = 32'hFF800000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
    } fp_unp_t;

    function automatic fp_unp_t fp_unpack(input logic [31:0] x);
        fp_unp_t u;
        u.sign = x[31];
        u.exp  = x[30:23];
        u.sig  = {|x[30:23], x[22:0]};
        return u;
    endfunction

    function automatic logic is_nan(input fp_unp_t u);
        return (u.exp == 8'hFF) && (|u.sig[22:0]);
    endfunction

    function automatic logic is_inf(input fp_unp_t u);
        return (u.exp == 8'hFF) && !(|u.sig[22:0]);
    endfunction

    function automatic logic is_zero(input fp_unp_t u);
        return u.exp == 8'h00;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - leading-zero counter; all-zero input returns W
module fp_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_value,
    output logic [CW-1:0] o_count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        o_count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_value[i]) o_count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/f_adder.sv
// rtl/f_adder.sv - 2-stage binary32 adder, RNE, flush-to-zero; FP_FLAGS_EN adds flags18
module f_adder
    import fp32_pkg::*;
(
    input  logic        clk18,
    input  logic        rst18,
    input  logic [31:0] a_original18,
    input  logic [31:0] b_original18,
`ifdef FP_FLAGS_EN
    output logic [3:0]  flags18,
`endif
    output logic [31:0] sum18
);

    fp_unp_t     w_ua, w_ub, w_ux, w_uy;
    logic [7:0]  w_diff;
    logic [49:0] w_ext;
    logic [26:0] w_x_al, w_y_al;
    logic [27:0] w_mant;
    logic        w_special, w_invalid;
    logic [31:0] w_spec_val;

    logic        r_s1_special, r_s1_sign;
    logic [31:0] r_s1_spec_val;
    logic [7:0]  r_s1_exp;
    logic [27:0] r_s1_mant;
`ifdef FP_FLAGS_EN
    logic        r_s1_invalid;
`endif

    assign w_ua   = fp_unpack(a_original18);
    assign w_ub   = fp_unpack(b_original18);
    assign w_ux   = (a_original18[30:0] >= b_original18[30:0]) ? w_ua : w_ub;
    assign w_uy   = (a_original18[30:0] >= b_original18[30:0]) ? w_ub : w_ua;
    assign w_diff = w_ux.exp - w_uy.exp;
    assign w_ext  = {w_uy.sig, 26'b0} >> w_diff;
    assign w_x_al = {w_ux.sig, 3'b000};
    // Sticky rides as the LSB so subtraction borrows correctly for rounding.
    assign w_y_al = (w_diff >= 8'd26) ? 27'd1 : {w_ext[49:24], |w_ext[23:0]};
    assign w_mant = (w_ux.sign == w_uy.sign) ? ({1'b0, w_x_al} + {1'b0, w_y_al})
                                             : ({1'b0, w_x_al} - {1'b0, w_y_al});

    always_comb begin
        w_special  = 1'b1;
        w_invalid  = 1'b0;
        w_spec_val = 32'h0;
        if (is_nan(w_ua) || is_nan(w_ub) ||
            (is_inf(w_ua) && is_inf(w_ub) && (w_ua.sign != w_ub.sign))) begin
            w_spec_val = CANON_NAN;
            w_invalid  = 1'b1;
        end else if (is_inf(w_ua)) begin
            w_spec_val = w_ua.sign ? NEG_INF : POS_INF;
        end else if (is_inf(w_ub)) begin
            w_spec_val = w_ub.sign ? NEG_INF : POS_INF;
        end else if (is_zero(w_ua) && is_zero(w_ub)) begin
            w_spec_val = {w_ua.sign & w_ub.sign, 31'b0};
        end else if (is_zero(w_ua)) begin
            w_spec_val = b_original18;
        end else if (is_zero(w_ub)) begin
            w_spec_val = a_original18;
        end else begin
            w_special = 1'b0;
        end
    end

    always_ff @(posedge clk18 or posedge rst18) begin
        if (rst18) begin
            r_s1_special  <= 1'b0;
            r_s1_spec_val <= 32'h0;
            r_s1_sign     <= 1'b0;
            r_s1_exp      <= 8'h0;
            r_s1_mant     <= 28'h0;
        end else begin
            r_s1_special  <= w_special;
            r_s1_spec_val <= w_spec_val;
            r_s1_sign     <= w_ux.sign;
            r_s1_exp      <= w_ux.exp;
            r_s1_mant     <= w_mant;
        end
    end

    logic [4:0]        w_lz;
    logic [26:0]       w_norm;
    logic signed [9:0] w_exp_n, w_exp_r;
    logic              w_round_up;
    logic [24:0]       w_sig_r;
    logic [22:0]       w_frac;
    logic [31:0]       w_result;

    fp_lzc #(.W(27)) u_lzc (
        .i_value (r_s1_mant[26:0]),
        .o_count (w_lz)
    );

    always_comb begin
        w_norm  = 27'h0;
        w_exp_n = 10'sd0;
        if (r_s1_mant[27]) begin
            w_norm  = {r_s1_mant[27:2], |r_s1_mant[1:0]};
            w_exp_n = $signed({2'b00, r_s1_exp}) + 10'sd1;
        end else begin
            w_norm  = r_s1_mant[26:0] << w_lz;
            w_exp_n = $signed({2'b00, r_s1_exp}) - $signed({5'b00000, w_lz});
        end
    end

    assign w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_sig_r    = {1'b0, w_norm[26:3]} + {24'h0, w_round_up};
    assign w_exp_r    = w_sig_r[24] ? (w_exp_n + 10'sd1) : w_exp_n;
    assign w_frac     = w_sig_r[24] ? w_sig_r[23:1] : w_sig_r[22:0];

    always_comb begin
        w_result = {r_s1_sign, w_exp_r[7:0], w_frac};
        if (r_s1_special)
            w_result = r_s1_spec_val;
        else if (r_s1_mant == 28'h0)
            w_result = 32'h0;
        else if (w_exp_r <= 10'sd0)
            w_result = {r_s1_sign, 31'b0};
        else if (w_exp_r >= 10'sd255)
            w_result = r_s1_sign ? NEG_INF : POS_INF;
    end

    always_ff @(posedge clk18 or posedge rst18) begin
        if (rst18) sum18 <= 32'h0;
        else       sum18 <= w_result;
    end

`ifdef FP_FLAGS_EN
    logic       w_of, w_uf;
    logic [3:0] w_flags;

    always_comb begin
        w_of    = 1'b0;
        w_uf    = 1'b0;
        w_flags = {r_s1_invalid, 3'b000};
        if (!r_s1_special && (r_s1_mant != 28'h0)) begin
            w_uf    = (w_exp_r <= 10'sd0);
            w_of    = !w_uf && (w_exp_r >= 10'sd255);
            w_flags = {1'b0, w_of, w_uf, (|w_norm[2:0]) | w_of | w_uf};
        end
    end

    always_ff @(posedge clk18 or posedge rst18) begin
        if (rst18) begin
            r_s1_invalid <= 1'b0;
            flags18      <= 4'h0;
        end else begin
            r_s1_invalid <= w_invalid;
            flags18      <= w_flags;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_invalid;
`endif

endmodule

// File: tb/tb_f_adder.sv
// tb/tb_f_adder.sv - directed-vector self-checking bench for f_adder
module tb_f_adder;

    logic        clk18 = 1'b0;
    logic        rst18;
    logic [31:0] a_original18, b_original18, sum18;
`ifdef FP_FLAGS_EN
    logic [3:0]  flags18;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk18 = ~clk18;

    f_adder dut (
        .clk18        (clk18),
        .rst18        (rst18),
        .a_original18 (a_original18),
        .b_original18 (b_original18),
`ifdef FP_FLAGS_EN
        .flags18      (flags18),
`endif
        .sum18        (sum18)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [3:0]  f;
    } vec_t;

    localparam int N = 16;
    vec_t vecs[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h42C80000, 32'h43480000, 32'h43960000, 4'b0000};
        vecs[1]  = '{32'h42C80000, 32'hC2480000, 32'h42480000, 4'b0000};
        vecs[2]  = '{32'hC2540000, 32'h420C0000, 32'hC1900000, 4'b0000};
        vecs[3]  = '{32'hC3960000, 32'hC2C60000, 32'hC3C78000, 4'b0000};
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h00000000, 4'b0000};
        vecs[5]  = '{32'h00000000, 32'hC32B0000, 32'hC32B0000, 4'b0000};
        vecs[6]  = '{32'h42C80000, 32'hC2C80000, 32'h00000000, 4'b0000};
        vecs[7]  = '{32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001};
        vecs[8]  = '{32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001};
        vecs[9]  = '{32'h4B800000, 32'h3F800000, 32'h4B800000, 4'b0001};
        vecs[10] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101};
        vecs[11] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000};
        vecs[12] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000};
        vecs[13] = '{32'h80000000, 32'h80000000, 32'h80000000, 4'b0000};
        vecs[14] = '{32'h00000000, 32'h80000000, 32'h00000000, 4'b0000};
        vecs[15] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000};

        rst18        = 1'b1;
        a_original18 = vecs[0].a;
        b_original18 = vecs[0].b;
        repeat (3) @(posedge clk18);
        #1;
        check("reset_sum", sum18, 32'h0);
`ifdef FP_FLAGS_EN
        check("reset_flags", {28'h0, flags18}, 32'h0);
`endif
        @(negedge clk18);
        rst18 = 1'b0;

        for (int c = 0; c <= N; c++) begin
            a_original18 = (c < N) ? vecs[c].a : 32'h0;
            b_original18 = (c < N) ? vecs[c].b : 32'h0;
            @(posedge clk18);
            #1;
            if (c >= 1) begin
                check($sformatf("vec%0d_sum", c - 1), sum18, vecs[c-1].s);
`ifdef FP_FLAGS_EN
                check($sformatf("vec%0d_flags", c - 1), {28'h0, flags18}, {28'h0, vecs[c-1].f});
`endif
            end
        end

        a_original18 = 32'h42C80000;
        b_original18 = 32'h43480000;
        @(posedge clk18);
        #1;
        a_original18 = 32'h42C80000;
        b_original18 = 32'hC2480000;
        @(posedge clk18);
        #1;
        check("pre_abort_sum", sum18, 32'h43960000);
        a_original18 = 32'hC2540000;
        b_original18 = 32'h420C0000;
        #2;
        rst18 = 1'b1;
        #1;
        check("async_reset_sum", sum18, 32'h0);
        a_original18 = 32'h0;
        b_original18 = 32'h0;
        repeat (2) @(posedge clk18);
        @(negedge clk18);
        rst18 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk18);
            #1;
            check($sformatf("no_ghost%0d", k), sum18, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/f_adder.md
Name: f_adder

Overview:
- Pipelined IEEE-754 single-precision (binary32) floating-point adder.
- Accepts a new operand pair every clock.
- Returns the rounded sum a fixed 2 cycles later.
- Datapath leaf block used wherever the design adds two fp32 values.

Parameters:
- None. Format is fixed at binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clk18  input  1  clock; all registers update on the rising edge.
- rst18  input  1  reset, asynchronous, active-high; clears every pipeline register.
- a_original18  input  32  operand A, binary32.
- b_original18  input  32  operand B, binary32.
- sum18  output  32  registered result A+B, binary32.

Behaviour:
- Reset:
  - While rst18=1, all pipeline registers and sum18 are 0x00000000 (+0).
  - Registers are released on the first rising edge after rst18 falls.
  - Asserting rst18 mid-operation discards in-flight sums immediately.
- Latency and throughput:
  - Operands sampled at edge N produce sum18 valid after edge N+2.
  - Throughput is 1 operation per cycle.
  - No handshake; the pipeline always advances.
- Stage 1 (unpack/align/add), registered:
  - Unpack each operand and restore the hidden 1.
  - Swap so the larger-magnitude operand is X (compare exponent, then fraction).
  - Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits.
  - Differences of 26 or more collapse the smaller operand into sticky.
  - Add significands if signs are equal, else subtract (X−Y). The result is never negative after the swap.
- Stage 2 (normalize/round/pack), registered into sum18:
  - On carry-out: shift right 1 and exponent+1.
  - Otherwise: leading-zero count, then left-shift, with exponent reduced accordingly.
  - Round to nearest, ties to even, using guard/round/sticky.
  - A rounding carry renormalizes (exponent+1).
- Special cases, resolved in stage 1 and carried through:
  - Either operand exponent=0 (zero or subnormal) is treated as signed zero (flush-to-zero on input).
  - Zero + X = X exactly, e.g. 0 + 0xC32B0000 = 0xC32B0000.
  - +0 + +0 = +0; −0 + −0 = −0; +0 + −0 = +0.
  - Exact cancellation (X + −X) = +0.
  - Result exponent ≤ 0 after normalize flushes to signed zero.
  - Result exponent ≥ 255 gives signed infinity (0x7F800000 / 0xFF800000).
  - Inf + finite = that inf. Inf + same-sign inf = inf.
  - Inf + opposite-sign inf = canonical NaN 0x7FC00000.
  - Any NaN input gives 0x7FC00000.

Optional Feature:
- Macro: FP_FLAGS_EN.
- Defined: adds output port flags18 [3:0] = {invalid, overflow, underflow, inexact}.
  - Flags are registered and aligned with sum18 (same 2-cycle latency).
  - Flags reset to 0.
  - invalid: NaN input or inf−inf.
  - overflow: finite inputs rounded to inf.
  - underflow: nonzero result flushed to zero.
  - inexact: any discarded nonzero G/R/S bits, or overflow/underflow.
- Not defined: port absent, flag logic not built. sum18 behaviour is identical either way.

Decomposition:
- Package fp32_pkg:
  - constants EXP_BIAS=127, EXP_MAX=255, FRAC_W=23, CANON_NAN=32'h7FC00000, POS_INF, NEG_INF.
  - typedef for the unpacked operand {sign, exp[7:0], sig[23:0]}.
  - is_nan / is_inf / is_zero functions.
- One natural sub-module: fp_lzc (24/27-bit leading-zero counter) used by stage-2 normalization.

Test Plan:
- Reset then 0x42C80000 + 0x43480000 (100+200) -> sum18=0x43960000 two edges later. sum18=0 while rst18=1.
- Back-to-back, one pair per cycle, in order:
  - 100 + −50 (0x42C80000, 0xC2480000) -> 0x42480000.
  - −53 + 35 (0xC2540000, 0x420C0000) -> 0xC1900000.
  - −300 + −99 (0xC3960000, 0xC2C60000) -> 0xC3C78000.
  - Results appear on consecutive cycles, each 2 cycles after its inputs.
- Zeros:
  - 0 + 0 -> 0x00000000.
  - 0x00000000 + 0xC32B0000 -> 0xC32B0000.
  - 0x42C80000 + 0xC2C80000 -> 0x00000000.
- Rounding/alignment:
  - 0x3F800000 + 0x33800000 (1 + 2^-24, tie) -> 0x3F800000.
  - 0x3F800001 + 0x33800000 -> 0x3F800002.
  - 0x4B800000 + 0x3F800000 -> 0x4B800000.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
  - With FP_FLAGS_EN: flags are overflow+inexact, then invalid, then invalid.
- Assert rst18 asynchronously mid-stream with two sums in flight -> sum18 goes to 0 immediately with no clock edge. Those sums are never emitted.
